pitch_speed_sched: RTL and testbench
====================================

PITCH_SPEED_SCHED -- requirements
Module: pitch_speed_sched

Interface
REQ-001 The block SHALL have parameter PW, default 10, the pitch bin width in bits.
REQ-002 The block SHALL have parameter PITCH_MAX, default 300, the pitch bin at or above which the level saturates.
REQ-003 The block SHALL have parameter NAVG, default 4, the samples averaged per command; it is a power of two, from 1 to 16.
REQ-004 The block SHALL have parameter TIMEOUT, default 1000000, the clk cycles without a pitch before a stop command is issued.
REQ-005 The ports SHALL be, clock and reset first:
  - clk  in  1  single clock, all logic on its rising edge.
  - reset_n  in  1  asynchronous active-low reset.
  - enable  in  1  scheduling enabled.
  - pitch_valid  in  1  single-cycle strobe marking a new pitch bin.
  - pitch_data  in  PW  peak FFT bin.
  - cmd_valid  out  1  command offered.
  - cmd_ready  in  1  consumer accepts the command.
  - cmd_level  out  4  averaged level, 0..15.
  - cmd_speed  out  2  speed class, 0..3.
  - silent  out  1  timeout stop is in force.

Function
REQ-006 Mapping SHALL be: lvl = 15 if pitch_data >= PITCH_MAX, else (pitch_data*16)/PITCH_MAX truncated, giving 0..15.
- The product SHALL be computed at width PW+4, with no overflow.
REQ-007 The FSM SHALL have states IDLE, ACCUM, ISSUE and STOP.
REQ-008 IDLE SHALL go to ACCUM when enable=1.
- On entry to ACCUM the sum, the sample count and the timeout counter SHALL be cleared.
REQ-009 In ACCUM, each pitch_valid SHALL add lvl to an 8-bit sum and increment the count.
- When the NAVG-th sample is added, avg = sum>>log2(NAVG) SHALL be latched and the FSM SHALL go to ISSUE on the next cycle.
- Latency SHALL be one cycle from the final pitch_valid to cmd_valid=1.
REQ-010 Speed SHALL be: avg 0..4 -> 1, avg 5..10 -> 2, avg 11..15 -> 3.
- Speed 0 SHALL be used only for stop commands.
REQ-011 In ACCUM, TIMEOUT consecutive cycles with no pitch_valid SHALL load the stop command (level 0, speed 0) and go to STOP.
- Any pitch_valid SHALL zero the timeout counter.
REQ-012 In ISSUE and STOP, cmd_valid SHALL be 1 and cmd_level/cmd_speed SHALL stay stable until the cycle with cmd_valid&&cmd_ready.
- After acceptance, cmd_valid SHALL drop on the next cycle.
REQ-013 After acceptance from ISSUE, the FSM SHALL return to ACCUM with the sum and count cleared and silent=0.
REQ-014 After acceptance from STOP, silent SHALL be 1 and the FSM SHALL return to ACCUM.
- silent SHALL clear only when a non-stop command is accepted.
- While silent=1, further timeouts SHALL NOT issue another stop.
REQ-015 pitch_valid arriving in ISSUE or STOP SHALL be discarded; no buffering.
REQ-016 If enable=0 in ACCUM, the FSM SHALL go to IDLE on the next cycle and discard partial sums.
- If enable=0 in ISSUE or STOP, the handshake SHALL complete first, then the FSM SHALL go to IDLE.
REQ-017 If the timeout and the NAVG-th sample occur in the same cycle, the sample SHALL win and the FSM SHALL go to ISSUE.
REQ-018 cmd_ready asserted while cmd_valid=0 SHALL have no effect.

Reset
REQ-019 reset_n=0 SHALL immediately set the following, asynchronously:
  - FSM=IDLE.
  - cmd_valid=0, cmd_level=0, cmd_speed=0.
  - silent=0.
  - sum, count, timeout counter and last-sent register all 0.
REQ-020 Reset asserted mid-handshake SHALL abandon the command; no command SHALL be re-offered after release.

Configuration
REQ-021 With macro PITCH_SCHED_DEDUP_EN defined, a computed ISSUE command whose level and speed both equal the last accepted command SHALL be dropped: no cmd_valid, and the FSM returns to ACCUM with the sum cleared.
REQ-022 Without PITCH_SCHED_DEDUP_EN, every completed average SHALL be issued, and the last-sent register SHALL be absent.

Structure
REQ-023 Package pitch_sched_pkg SHALL hold the FSM state enum, the cmd struct (level, speed), the speed-threshold constants 4/10 and the function mapping bin to level.
REQ-024 The bin-to-level mapper SHALL be the single sub-module pitch_level_map, combinational, parameterised by PW and PITCH_MAX.

Verification
REQ-025 Mapping scenario: enable=1, NAVG=4, four strobes of pitch 150 with cmd_ready=1 -> one cmd_valid one cycle after the 4th strobe, level 8, speed 2.
REQ-026 Backpressure scenario: cmd_ready=0 for 20 cycles, with 3 pitch strobes during ISSUE -> cmd stable for all 20 cycles, accepted on the cycle ready rises, the 3 strobes are not counted.
REQ-027 Timeout scenario: TIMEOUT=50, no strobes -> stop command (0,0) at cycle 50, silent=1 after acceptance, no second stop after another 100 idle cycles.
REQ-028 Saturation scenario: pitch 1023 and pitch 300 -> level 15, speed 3.
- Pitch 299 -> level 15; pitch 0 -> level 0, speed 1.
REQ-029 Dedup scenario: with PITCH_SCHED_DEDUP_EN, two identical averages of pitch 150 -> exactly one command.
- Without the macro -> two commands.
REQ-030 Reset scenario: assert reset_n=0 during ISSUE -> cmd_valid=0 within the same cycle, FSM returns to IDLE, no stale command after release.

Source files
------------

// File: rtl/pitch_sched_pkg.sv
// Shared types and helpers for the pitch-driven speed scheduler: FSM states,
// command struct, speed thresholds and the bin-to-level arithmetic.
package pitch_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ISSUE, S_STOP} state_t;

  typedef struct packed {
    logic [3:0] level;
    logic [1:0] speed;
  } cmd_t;

  localparam logic [3:0] SPD_T1 = 4'd4;
  localparam logic [3:0] SPD_T2 = 4'd10;

  // Speed 0 is reserved for stop commands, so averages always map to 1..3.
  function automatic logic [1:0] speed_of(input logic [3:0] avg);
    if (avg <= SPD_T1)      return 2'd1;
    else if (avg <= SPD_T2) return 2'd2;
    else                    return 2'd3;
  endfunction

  // prod16 is bin*16; below saturation the quotient is guaranteed < 16.
  function automatic logic [3:0] bin_to_level(input logic [31:0] prod16,
                                              input logic        sat,
                                              input logic [31:0] pmax);
    return sat ? 4'd15 : 4'(prod16 / pmax);
  endfunction

endpackage

// File: rtl/pitch_level_map.sv
// Combinational pitch-bin to 0..15 level mapper, saturating at PITCH_MAX.
module pitch_level_map
  import pitch_sched_pkg::*;
#(
  parameter int unsigned PW        = 10,
  parameter int unsigned PITCH_MAX = 300
) (
  input  logic [PW-1:0] i_pitch,
  output logic [3:0]    o_level
);

  logic [PW+3:0] w_prod;
  logic          w_sat;

  assign w_prod  = {i_pitch, 4'b0000};
  assign w_sat   = 32'(i_pitch) >= PITCH_MAX;
  assign o_level = bin_to_level(32'(w_prod), w_sat, 32'(PITCH_MAX));

endmodule

// File: rtl/pitch_speed_sched.sv
// Averages NAVG pitch levels into level/speed commands with a valid/ready
// handshake and a silence timeout. PITCH_SCHED_DEDUP_EN drops repeated commands.
module pitch_speed_sched
  import pitch_sched_pkg::*;
#(
  parameter int unsigned PW        = 10,
  parameter int unsigned PITCH_MAX = 300,
  parameter int unsigned NAVG      = 4,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          pitch_valid,
  input  logic [PW-1:0] pitch_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [3:0]    cmd_level,
  output logic [1:0]    cmd_speed,
  output logic          silent
);

  localparam int unsigned SH = $clog2(NAVG);
  localparam int unsigned CW = $clog2(NAVG + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        r_state, w_next;
  logic [7:0]    r_sum;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_to;
  cmd_t          r_cmd;
  logic          r_silent;

  logic [3:0] w_lvl;
  logic [7:0] w_sum_nxt;
  logic [3:0] w_avg;
  cmd_t       w_new;
  logic       w_last_smp, w_timeout, w_dup, w_accept, w_stay;

  pitch_level_map #(.PW(PW), .PITCH_MAX(PITCH_MAX)) u_map (
    .i_pitch (pitch_data),
    .o_level (w_lvl)
  );

  assign w_sum_nxt  = r_sum + {4'd0, w_lvl};
  assign w_avg      = 4'(w_sum_nxt >> SH);
  assign w_new      = '{level: w_avg, speed: speed_of(w_avg)};
  assign w_last_smp = pitch_valid && (r_cnt == CW'(NAVG - 1));
  assign w_timeout  = !pitch_valid && (r_to == TW'(TIMEOUT - 1));
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_stay     = (r_state == S_ACCUM) && (w_next == S_ACCUM);

`ifdef PITCH_SCHED_DEDUP_EN
  cmd_t r_last;
  assign w_dup = (w_new == r_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_last <= '0;
    else if (w_accept) r_last <= r_cmd;
  end
`else
  assign w_dup = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_ACCUM;
      S_ACCUM: begin
        if (!enable)                      w_next = S_IDLE;
        else if (w_last_smp)              w_next = w_dup ? S_ACCUM : S_ISSUE;
        else if (w_timeout && !r_silent)  w_next = S_STOP;
      end
      S_ISSUE, S_STOP: if (cmd_ready) w_next = enable ? S_ACCUM : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_to     <= '0;
      r_cmd    <= '0;
      r_silent <= 1'b0;
    end else begin
      r_state <= w_next;
      // Accumulators only live inside ACCUM; a dropped duplicate restarts them.
      if (!w_stay || w_last_smp) begin
        r_sum <= '0;
        r_cnt <= '0;
        r_to  <= '0;
      end else if (pitch_valid) begin
        r_sum <= w_sum_nxt;
        r_cnt <= r_cnt + 1'b1;
        r_to  <= '0;
      end else if (w_timeout) begin
        r_to  <= '0;
      end else begin
        r_to  <= r_to + 1'b1;
      end
      if (r_state == S_ACCUM && w_next == S_ISSUE) r_cmd <= w_new;
      else if (r_state == S_ACCUM && w_next == S_STOP) r_cmd <= '0;
      if (w_accept) r_silent <= (r_state == S_STOP);
    end
  end

  assign cmd_valid = (r_state == S_ISSUE) || (r_state == S_STOP);
  assign cmd_level = r_cmd.level;
  assign cmd_speed = r_cmd.speed;
  assign silent    = r_silent;

endmodule

// File: tb/tb_pitch_speed_sched.sv
// Scoreboard bench for pitch_speed_sched (NAVG=4, TIMEOUT=50).
module tb_pitch_speed_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       pitch_valid;
  logic [9:0] pitch_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_level;
  logic [1:0] cmd_speed;
  logic       silent;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [5:0] sb_q[$];
  logic [5:0] m_last = '0;

  always #5 clk = ~clk;

  pitch_speed_sched #(.PW(10), .PITCH_MAX(300), .NAVG(4), .TIMEOUT(50)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pitch_valid (pitch_valid),
    .pitch_data  (pitch_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_level   (cmd_level),
    .cmd_speed   (cmd_speed),
    .silent      (silent)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mlvl(input int p);
    return (p >= 300) ? 15 : (p * 16) / 300;
  endfunction

  function automatic int mspd(input int a);
    return (a <= 4) ? 1 : (a <= 10) ? 2 : 3;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_cmd(input int l, input int s);
    logic [5:0] c;
    c = {4'(l), 2'(s)};
`ifdef PITCH_SCHED_DEDUP_EN
    if (c == m_last) return;
`endif
    m_last = c;
    sb_q.push_back(c);
  endtask

  task automatic send4(input int p0, input int p1, input int p2, input int p3);
    int ps[4];
    int a;
    ps = '{p0, p1, p2, p3};
    a = (mlvl(p0) + mlvl(p1) + mlvl(p2) + mlvl(p3)) >> 2;
    expect_cmd(a, mspd(a));
    foreach (ps[i]) begin
      pitch_valid = 1'b1;
      pitch_data  = 10'(ps[i]);
      tick();
    end
    pitch_valid = 1'b0;
  endtask

  // Acceptance monitor: sampled mid-cycle, the handshake completes on the next edge.
  always @(negedge clk) begin
    if (reset_n && cmd_valid && cmd_ready) begin
      n_acc++;
      if (sb_q.size() == 0) chk("unexpected_cmd", 1, 0);
      else begin
        logic [5:0] e;
        e = sb_q.pop_front();
        chk("cmd_level", int'(cmd_level), int'(e[5:2]));
        chk("cmd_speed", int'(cmd_speed), int'(e[1:0]));
      end
    end
  end

  initial begin
    int tab[8][4];
    int n;
    int a0;
    logic ok;
    reset_n = 1'b0; enable = 1'b0; pitch_valid = 1'b0; pitch_data = '0; cmd_ready = 1'b0;
    #12;
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_level", int'(cmd_level), 0);
    chk("rst_speed", int'(cmd_speed), 0);
    chk("rst_silent", int'(silent), 0);
    reset_n = 1'b1;
    enable = 1'b1; cmd_ready = 1'b1;
    tick();

    // Basic mapping with one-cycle latency and drop after acceptance
    send4(150, 150, 150, 150);
    chk("latency_valid", int'(cmd_valid), 1);
    tick();
    chk("valid_drop", int'(cmd_valid), 0);
    tick();

    // Saturation and speed-threshold boundaries
    tab = '{'{1023, 300, 1023, 300}, '{299, 299, 299, 299}, '{0, 0, 0, 0},
            '{0, 75, 150, 299}, '{75, 75, 75, 75}, '{94, 94, 94, 94},
            '{207, 207, 207, 207}, '{188, 188, 188, 188}};
    foreach (tab[i]) begin
      send4(tab[i][0], tab[i][1], tab[i][2], tab[i][3]);
      repeat (2) tick();
    end

    // Backpressure: command held stable, strobes during ISSUE ignored
    cmd_ready = 1'b0;
    send4(207, 207, 207, 207);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pitch_valid = (i >= 3 && i < 6);
      pitch_data  = '0;
      if (!(cmd_valid && cmd_level == 4'd11 && cmd_speed == 2'd3)) ok = 1'b0;
      tick();
    end
    pitch_valid = 1'b0;
    chk("bp_stable", int'(ok), 1);
    cmd_ready = 1'b1;
    tick();
    chk("bp_drop", int'(cmd_valid), 0);
    send4(299, 299, 299, 299);
    repeat (2) tick();

    // Timeout from a clean ACCUM entry
    enable = 1'b0; repeat (2) tick();
    enable = 1'b1; tick();
    expect_cmd(0, 0);
    n = 0;
    while (n < 200 && !cmd_valid) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 50);
    tick();
    chk("silent_set", int'(silent), 1);
    ok = 1'b0;
    repeat (100) begin
      if (cmd_valid) ok = 1'b1;
      tick();
    end
    chk("no_second_stop", int'(ok), 0);
    send4(150, 150, 150, 150);
    repeat (2) tick();
    chk("silent_clear", int'(silent), 0);

    // Disable mid-accumulation discards the partial sum
    pitch_valid = 1'b1; pitch_data = 10'd1023;
    repeat (2) tick();
    pitch_valid = 1'b0; enable = 1'b0;
    tick(); tick();
    enable = 1'b1; tick();
    send4(0, 0, 0, 0);
    repeat (2) tick();

    // Reset during ISSUE abandons the command
    cmd_ready = 1'b0;
    a0 = sb_q.size();
    send4(150, 150, 150, 150);
    if (sb_q.size() > a0) void'(sb_q.pop_back());
    chk("issue_before_rst", int'(cmd_valid), 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_valid", int'(cmd_valid), 0);
    chk("rst_async_level", int'(cmd_level), 0);
    m_last = '0;
    #6 reset_n = 1'b1;
    cmd_ready = 1'b1;
    ok = 1'b0;
    repeat (10) begin
      tick();
      if (cmd_valid) ok = 1'b1;
    end
    chk("no_stale_cmd", int'(ok), 0);

    // Two identical averages
    a0 = n_acc;
    send4(150, 150, 150, 150);
    repeat (2) tick();
    send4(150, 150, 150, 150);
    repeat (2) tick();
`ifdef PITCH_SCHED_DEDUP_EN
    chk("dedup_count", n_acc - a0, 1);
`else
    chk("dedup_count", n_acc - a0, 2);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
